bin_to_bcd_seq: RTL

- Parametrised, multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble) with one iteration per clock.
- Drives score, level and line-count displays where operands exceed 8 bits.
- Uses a start/ready/valid handshake, saturates on digit overflow, and produces a leading-zero blanking mask for the seven-segment driver.

---
 rtl/bin_to_bcd_seq_pkg.sv | 19 +
 rtl/bin_to_bcd_seq_digit_adj.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the shift.
  localparam logic [3:0] BCD_CORR = 4'd3;
  localparam logic [3:0] BCD_THR  = 4'd5;

  // Decimal digits needed to show any width-bit unsigned value:
  // ceil(width * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational "if >= 5 add 3" cell for one BCD digit (wraps modulo 16).
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Correct the digit so the following left shift carries correctly into the next decade.
  always_comb begin
    dout = din;
    if (din >= BCD_THR) dout = din + BCD_CORR;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (one double-dabble iteration per clock)
// with start/ready/valid handshake, overflow saturation and leading-zero mask.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BIN_W - 1);
  localparam logic [ACC_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_sr_q, bin_sr_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_adj;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                valid_q, valid_d;

  // Digit i is blanked when it and every more-significant digit are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [ACC_W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              lead;
    m    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead = lead & (v[4*i +: 4] == 4'd0);
      m[i] = lead;
    end
    return m;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, load outputs on the final iteration.
  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    blank_d  = blank_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          bin_sr_d = bin;
          acc_d    = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        // Shift {corrected accumulator, binary} left; the bit leaving the top is overflow.
        bin_sr_d = bin_sr_q << 1;
        acc_d    = {acc_adj[ACC_W-2:0], bin_sr_q[BIN_W-1]};
        carry_d  = carry_q | acc_adj[ACC_W-1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          valid_d = 1'b1;
          if (carry_d) begin
            bcd_d   = ALL_NINES;
            ovf_d   = 1'b1;
            blank_d = '0;
          end else begin
            bcd_d   = acc_d;
            ovf_d   = 1'b0;
            blank_d = blank_mask(acc_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_sr_q <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      blank_q  <= BLANK_RST;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      blank_q  <= blank_d;
      valid_q  <= valid_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign valid    = valid_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign blank    = blank_q;

endmodule
